// File: rtl/hps_reset_req_sequencer.sv
// Push-button to HPS reset request sequencer: debounces the keys, classifies
// short/long presses and issues one active-low f2h reset request at a time.

module hps_rrs_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_n,
    output logic out_n
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // Any cycle where the input agrees with the held state restarts the run.
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (in_n != out_q) begin
            if (cnt_q == CW'(CYCLES - 1)) out_d = in_n;
            else                          cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_n = out_q;
endmodule

module hps_reset_req_sequencer #(
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int LONG_CYCLES        = 150000000,
    parameter int PULSE_CYCLES       = 64,
    parameter int ACK_TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W              = 28
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [1:0] button_n,
    input  logic       enable,
    input  logic       h2f_reset_n,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       busy,
    output logic [1:0] last_req,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRESS, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_RELEASE
    } state_e;

    localparam logic [1:0] K_WARM  = 2'b01;
    localparam logic [1:0] K_COLD  = 2'b10;
    localparam logic [1:0] K_DEBUG = 2'b11;

    logic [1:0] btn_s1_q, btn_s2_q, btn_db_n;
    logic       ack_s1_q, ack_s2_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
            ack_s1_q <= 1'b1;
            ack_s2_q <= 1'b1;
        end else begin
            btn_s1_q <= button_n;
            btn_s2_q <= btn_s1_q;
            ack_s1_q <= h2f_reset_n;
            ack_s2_q <= ack_s1_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        hps_rrs_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .in_n  (btn_s2_q[i]),
            .out_n (btn_db_n[i])
        );
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       kind_q, kind_d, last_req_q, last_req_d;
    logic             terr_q, terr_d;
    logic [2:0]       req_n_q, req_n_d;  // {cold, warm, debug}

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        kind_d     = kind_q;
        last_req_d = last_req_q;
        terr_d     = terr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable && !btn_db_n[0]) begin
                    state_d = S_PRESS;
                end else if (enable && !btn_db_n[1]) begin
                    state_d = S_PULSE;
                    kind_d  = K_DEBUG;
                end
            end
            S_PRESS: begin
                if (btn_db_n[0]) begin
                    state_d = S_PULSE;
                    kind_d  = K_WARM;
                end else if (cnt_q >= CNT_W'(LONG_CYCLES - 1)) begin
                    state_d = S_PULSE;
                    kind_d  = K_COLD;
                end
            end
            S_PULSE: begin
                if (cnt_q >= CNT_W'(PULSE_CYCLES - 1)) begin
                    state_d = (kind_q == K_DEBUG) ? S_RELEASE : S_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LO: begin
                if (!ack_s2_q) begin
                    state_d = S_WAIT_HI;
                end else if (cnt_q >= CNT_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    terr_d  = 1'b1;
                end
            end
            S_WAIT_HI: begin
                // >= rather than ==: the count may pass the limit while moving out of WAIT_LO
                if (ack_s2_q) begin
                    state_d = S_RELEASE;
                end else if (cnt_q >= CNT_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    terr_d  = 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d = '0;
                if (&btn_db_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_PULSE && state_q != S_PULSE) begin
            cnt_d      = '0;
            last_req_d = kind_d;
            terr_d     = 1'b0;
        end
        req_n_d    = 3'b111;
        req_n_d[2] = !(state_q == S_PULSE && kind_q == K_COLD);
        req_n_d[1] = !(state_q == S_PULSE && kind_q == K_WARM);
        req_n_d[0] = !(state_q == S_PULSE && kind_q == K_DEBUG);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            kind_q     <= '0;
            last_req_q <= '0;
            terr_q     <= 1'b0;
            req_n_q    <= 3'b111;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kind_q     <= kind_d;
            last_req_q <= last_req_d;
            terr_q     <= terr_d;
            req_n_q    <= req_n_d;
        end
    end

    assign f2h_cold_reset_req_n  = req_n_q[2];
    assign f2h_warm_reset_req_n  = req_n_q[1];
    assign f2h_debug_reset_req_n = req_n_q[0];
    assign busy                  = (state_q != S_IDLE);
    assign last_req              = last_req_q;
    assign timeout_err           = terr_q;
endmodule

// File: doc/hps_reset_req_sequencer.md
Name: hps_reset_req_sequencer

Overview:
- Converts board push-button activity into properly sequenced HPS reset requests: f2h warm, cold and debug reset requests, all active-low.
- Sits in the FPGA fabric between the raw button/dipsw pins and the hps_0 f2h_*_reset_req_reset_n inputs.
- Button[0] short press requests a warm reset; a long hold requests a cold reset. Button[1] requests a debug reset.
- After a warm or cold request, the block waits for the HPS to acknowledge via h2f_reset_n (a low-then-high cycle) or times out.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the debounced button state changes (20 ms at 50 MHz).
- LONG_CYCLES, 150000000: hold duration at or above which button[0] means a cold reset (3 s).
- PULSE_CYCLES, 64: number of cycles a request output is held low.
- ACK_TIMEOUT_CYCLES, 50000000: maximum cycles spent waiting for the HPS acknowledge.
- CNT_W, 28: width of the shared timing counter; must hold LONG_CYCLES and ACK_TIMEOUT_CYCLES.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- button_n  in  2  raw active-low keys, asynchronous to clk_clk; [0] reset key, [1] debug key.
- enable  in  1  from a dipsw; when 0, new presses are ignored.
- h2f_reset_n  in  1  HPS h2f reset, active-low; serves as the acknowledge.
- f2h_cold_reset_req_n  out  1  cold reset request, active-low.
- f2h_warm_reset_req_n  out  1  warm reset request, active-low.
- f2h_debug_reset_req_n  out  1  debug reset request, active-low.
- busy  out  1  high whenever the FSM is not in IDLE.
- last_req  out  2  last request issued: 00 none, 01 warm, 10 cold, 11 debug.
- timeout_err  out  1  sticky; set on acknowledge timeout, cleared when the next request is issued.

Behaviour:
- Reset values, applied asynchronously: all three req_n = 1, busy = 0, last_req = 00, timeout_err = 0, FSM = IDLE, debounced state = released, counters = 0.
- Synchronisation: each button_n bit passes through a 2-FF synchronizer, and h2f_reset_n through its own 2-FF synchronizer.
- Debounce: per bit, the debounced state changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts that bit's count.
- Request outputs are registered and glitch-free. At most one request output is low at any time.
- IDLE:
  - If enable = 1 and debounced[0] is pressed: go to PRESS, clear the counter.
  - Else if enable = 1 and debounced[1] is pressed: go to PULSE with kind = debug.
  - If both are pressed in the same cycle, button[0] wins.
- PRESS: the counter increments each cycle.
  - If debounced[0] is released while counter < LONG_CYCLES: go to PULSE with kind = warm.
  - If counter reaches LONG_CYCLES-1 while still pressed: go to PULSE with kind = cold, without waiting for release.
- PULSE:
  - The selected req_n is driven low for exactly PULSE_CYCLES cycles, starting the cycle after entry.
  - last_req is updated and timeout_err cleared on entry.
  - Exit: debug goes to RELEASE; warm and cold go to WAIT_LO with the counter cleared.
- WAIT_LO: wait for synced h2f_reset_n = 0, then go to WAIT_HI.
- WAIT_HI: wait for synced h2f_reset_n = 1, then go to RELEASE.
- Acknowledge timeout:
  - One counter spans WAIT_LO and WAIT_HI combined.
  - If it reaches ACK_TIMEOUT_CYCLES-1 first: set timeout_err and go to RELEASE.
  - If the acknowledge arrives on the same cycle as the timeout, the acknowledge wins and timeout_err stays 0.
- RELEASE: wait until both debounced buttons are released, then go to IDLE. This prevents a held key from re-triggering.
- enable falling mid-operation only blocks new starts; an in-flight sequence completes.
- busy is combinational from FSM state != IDLE, taken from a registered state.
- The counter saturates and never wraps.

Test Plan (overrides: DEBOUNCE_CYCLES=4, LONG_CYCLES=40, PULSE_CYCLES=3, ACK_TIMEOUT_CYCLES=30):
- Warm reset: press button_n[0] for 10 cycles with clean edges. Expect f2h_warm_reset_req_n low exactly 3 cycles after the debounced release, last_req = 01, and the other req_n held at 1. Then drive h2f_reset_n low for 5 cycles and high again; expect busy to return to 0.
- Cold reset: hold button_n[0] for 60 cycles. Expect f2h_cold_reset_req_n low for 3 cycles beginning about 40 cycles after the debounced press, with no warm pulse, last_req = 10, and busy held high until release.
- Bounce rejection: toggle button_n[0] every 2 cycles for 30 cycles, then leave it released. Expect no request output and busy = 0 throughout.
- Debug and priority:
  - Press button[1] alone: expect f2h_debug_reset_req_n low 3 cycles, last_req = 11, and no acknowledge wait.
  - Press both buttons simultaneously: expect a warm or cold request only.
- Acknowledge timeout: warm request with h2f_reset_n held at 1. Expect timeout_err = 1 30 cycles after the pulse ends; the next request clears it. Also check enable = 0: a press yields no pulse.
- Reset mid-operation: assert reset_reset during PULSE. Expect all req_n = 1, busy = 0 and last_req = 00 in the same cycle (asynchronous), and no pulse after reset is released while the button is still held until a fresh debounced press.
